// File: rtl/rto_arb_pkg.sv
// Shared types and constants for the RTO output arbiter: word type, channel-index width helper,
// and the drop counter ceiling.
package rto_arb_pkg;
  localparam int DATA_W_DEF = 128;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef logic [DATA_W_DEF-1:0] rto_word_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rto_arb_pend_fifo.sv
// Per-channel pending buffer: single-clock FIFO with a registered occupancy count.
// Storage is not reset; pointers and count are, so stale entries are never visible.
module rto_arb_pend_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      // push+pop together leaves the count unchanged
      case ({push, pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_cnt == '0);
  assign full  = (r_cnt == CW'(DEPTH));
endmodule

// File: rtl/rto_output_arbiter.sv
// Merges per-channel RTO match pulses into one valid/ready stream: per-channel pending FIFOs,
// round-robin grant into a single output register, and drop reporting for matches hitting a full FIFO.
module rto_output_arbiter
  import rto_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int PEND_DEPTH = 4,
  localparam int CW        = ch_idx_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CW-1:0]            out_ch,
  output logic [NUM_CH-1:0]        pend_empty,
  output logic                     drop_error,
  output logic [NUM_CH-1:0]        drop_mask,
  output logic [15:0]              drop_count
);
  logic [NUM_CH-1:0]             w_full, w_empty, w_push, w_drop, w_pop;
  logic [NUM_CH-1:0][DATA_W-1:0] w_dout;
  logic                          w_load_en, w_any;
  logic [CW-1:0]                 w_gnt, w_ptr_nxt;
  logic [16:0]                   w_cnt_sum;
  logic [15:0]                   w_cnt_nxt;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CW-1:0]     r_out_ch, r_ptr;
  logic              r_drop_error;
  logic [NUM_CH-1:0] r_drop_mask;
  logic [15:0]       r_drop_count;

  // Full check uses the registered count, so a same-cycle pop never makes room for a push.
  assign w_push = ch_valid & ~w_full;
  assign w_drop = ch_valid &  w_full;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rto_arb_pend_fifo #(.DEPTH(PEND_DEPTH), .W(DATA_W)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (flush),
      .push    (w_push[k]),
      .pop     (w_pop[k]),
      .din     (ch_data[k*DATA_W +: DATA_W]),
      .dout    (w_dout[k]),
      .empty   (w_empty[k]),
      .full    (w_full[k])
    );
  end

  function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] ne, input logic [CW-1:0] ptr);
    logic [CW-1:0] idx;
    logic          found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = CW'((int'(ptr) + i) % NUM_CH);
      if (!found && ne[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_load_en = ~r_out_valid | out_ready;
  assign w_any     = |(~w_empty);
  assign w_gnt     = rr_pick(~w_empty, r_ptr);
  assign w_ptr_nxt = (w_gnt == CW'(NUM_CH-1)) ? '0 : w_gnt + 1'b1;

  always_comb begin
    w_pop = '0;
    if (w_load_en && w_any) w_pop[w_gnt] = 1'b1;
  end

  assign w_cnt_sum = {1'b0, r_drop_count} + 17'($countones(w_drop));
  assign w_cnt_nxt = w_cnt_sum[16] ? DROP_CNT_MAX : w_cnt_sum[15:0];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
      r_ptr        <= '0;
      r_drop_error <= 1'b0;
      r_drop_mask  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_load_en) begin
        if (w_any) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_dout[w_gnt];
          r_out_ch    <= w_gnt;
          r_ptr       <= w_ptr_nxt;
        end else begin
          r_out_valid <= 1'b0;
        end
      end
      r_drop_error <= |w_drop;
      r_drop_mask  <= w_drop;
      r_drop_count <= w_cnt_nxt;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_ch     = r_out_ch;
  assign pend_empty = w_empty;
  assign drop_error = r_drop_error;
  assign drop_mask  = r_drop_mask;
  assign drop_count = r_drop_count;
endmodule

// File: tb/tb_rto_output_arbiter.sv
// Directed bench for rto_output_arbiter: expected words go into a scoreboard queue, a negedge
// monitor pops and compares on every accepted output word and checks hold stability.
module tb_rto_output_arbiter;
  import rto_arb_pkg::*;

  localparam int NCH = 4;
  localparam int DW  = 128;

  typedef struct {
    logic [1:0] ch;
    rto_word_t  data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset_n, flush, out_ready;
  logic [NCH-1:0]   ch_valid;
  logic [NCH*DW-1:0] ch_data;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_ch;
  logic [NCH-1:0]   pend_empty;
  logic             drop_error;
  logic [NCH-1:0]   drop_mask;
  logic [15:0]      drop_count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data;
  logic [1:0]    hold_ch;

  rto_output_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .PEND_DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .ch_valid   (ch_valid),
    .ch_data    (ch_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .pend_empty (pend_empty),
    .drop_error (drop_error),
    .drop_mask  (drop_mask),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic expect_w(input logic [1:0] ch, input logic [DW-1:0] d);
    exp_t e;
    e.ch   = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  // Monitor: compares every accepted word against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && !flush && out_valid) begin
      if (hold_prev) begin
        checks++;
        if (out_data !== hold_data || out_ch !== hold_ch) begin
          errors++;
          $display("FAIL hold: got ch%0d %0h expected ch%0d %0h", out_ch, out_data, hold_ch, hold_data);
        end
      end
      if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got ch%0d %0h with empty scoreboard", out_ch, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_ch !== e.ch || out_data !== e.data) begin
            errors++;
            $display("FAIL word: got ch%0d %0h expected ch%0d %0h", out_ch, out_data, e.ch, e.data);
          end
        end
      end
    end
    hold_prev = reset_n && !flush && out_valid && !out_ready;
    hold_data = out_data;
    hold_ch   = out_ch;
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    ch_valid  = 4'hF;
    ch_data   = '0;

    // 1. reset with matches asserted: all ignored
    repeat (3) step();
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_drop_count", 32'(drop_count), 0);
    chk("reset_pend_empty", 32'(pend_empty), 32'hF);
    ch_valid = '0;
    reset_n  = 1'b1;
    step();
    chk("post_reset_out_valid", 32'(out_valid), 0);

    // 2. single match on ch2, one-cycle latency
    ch_valid = 4'b0100;
    ch_data[2*DW +: DW] = 128'hA5;
    expect_w(2'd2, 128'hA5);
    step();
    ch_valid = '0;
    chk("single_not_same_edge", 32'(out_valid), 0);
    step();
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_ch", 32'(out_ch), 2);
    step();
    chk("single_out_valid_clr", 32'(out_valid), 0);

    // 3. simultaneous matches from pointer 0 rotate 0,1,2,3
    do_flush();
    for (int k = 0; k < NCH; k++) begin
      ch_data[k*DW +: DW] = 128'hC0 + 128'(k);
      expect_w(2'(k), 128'hC0 + 128'(k));
    end
    ch_valid = 4'hF;
    step();
    ch_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      step();
      chk("rr_seq_ch", 32'(out_ch), 32'(k));
    end
    step();
    chk("rr_seq_done", 32'(out_valid), 0);
    // pointer back at 0: ch0 beats ch1
    ch_data[0 +: DW]  = 128'hD0;
    ch_data[DW +: DW] = 128'hD1;
    expect_w(2'd0, 128'hD0);
    expect_w(2'd1, 128'hD1);
    ch_valid = 4'b0011;
    step();
    ch_valid = '0;
    step();
    chk("rr_ptr_wrap_ch", 32'(out_ch), 0);
    repeat (2) step();

    // 4. backpressure on ch0: 6 pulses, 5 held, 1 dropped
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ch_valid = 4'b0001;
      ch_data[0 +: DW] = 128'hB000 + 128'(k);
      if (k < 5) expect_w(2'd0, 128'hB000 + 128'(k));
      step();
    end
    ch_valid = '0;
    chk("bp_drop_error", 32'(drop_error), 1);
    chk("bp_drop_mask", 32'(drop_mask), 32'h1);
    chk("bp_drop_count", 32'(drop_count), 1);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_pend_ch0", 32'(pend_empty), 32'hE);
    step();
    chk("bp_drop_pulse_clr", 32'(drop_error), 0);
    out_ready = 1'b1;
    repeat (6) step();
    chk("bp_drained_valid", 32'(out_valid), 0);
    chk("bp_drained_q", 32'(exp_q.size()), 0);

    // 5. saturation: 3 + 4*(K-5) drops after K edges of all-channel matches
    do_flush();
    out_ready = 1'b0;
    ch_valid  = 4'hF;
    repeat (5) step();
    chk("sat_first_mask", 32'(drop_mask), 32'hE);
    chk("sat_first_count", 32'(drop_count), 3);
    repeat (5) step();
    chk("sat_count_10", 32'(drop_count), 23);
    repeat (17590) step();
    chk("sat_count_max", 32'(drop_count), 32'hFFFF);
    step();
    chk("sat_no_wrap", 32'(drop_count), 32'hFFFF);
    ch_valid = '0;

    // 6. flush mid-stream with partly full buffers and a held output word
    do_flush();
    ch_valid = 4'hF;
    repeat (2) step();
    ch_valid = '0;
    chk("flush_pre_valid", 32'(out_valid), 1);
    do_flush();
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_pend_empty", 32'(pend_empty), 32'hF);
    chk("flush_drop_count", 32'(drop_count), 0);
    out_ready = 1'b1;
    ch_data[3*DW +: DW] = 128'hF00D;
    expect_w(2'd3, 128'hF00D);
    ch_valid = 4'b1000;
    step();
    ch_valid = '0;
    step();
    chk("flush_next_valid", 32'(out_valid), 1);
    step();
    chk("final_q_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
